lsu_mem_stage: RTL

Load/store unit for the MEM stage of the 5-stage RV32I pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns load/store requests into transactions on a req/gnt/rvalid data-memory bus and aligns, masks and sign-extends load data. While a transaction is outstanding it stalls the pipeline and presents a bubble to MEM/WB.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/lsu_mem_stage_if.sv | 21 ++
 rtl/load_align.sv | 37 +++
 rtl/lsu_mem_stage.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: load/store funct3 encodings, the LSU state
// encoding and the alignment/legality check used by the MEM-stage LSU.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE      = 2'd0,
        LSU_WAIT_GNT  = 2'd1,
        LSU_WAIT_RESP = 2'd2
    } lsu_state_e;

    // True when the access is misaligned for its size or funct3 is not a
    // legal load/store encoding.
    function automatic logic lsu_fault(input logic [2:0] funct3, input logic [1:0] off);
        logic f;
        case (funct3)
            F3_B, F3_BU: f = 1'b0;
            F3_H, F3_HU: f = off[0];
            F3_W:        f = (off != 2'b00);
            default:     f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Data-memory bus (req/gnt/rvalid). The LSU is the master, memory the slave.
interface lsu_mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword from a read word and sign- or
// zero-extends it according to the load funct3. Purely combinational.
module load_align
    import riscv_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = i_rdata[8*gi +: 8];
        end
    endgenerate

    // Pick the byte/half at the offset and extend it to 32 bits.
    always_comb begin
        byte_sel = lane[i_off];
        half_sel = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_B:    o_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   o_data = {24'h0, byte_sel};
            F3_H:    o_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   o_data = {16'h0, half_sel};
            F3_W:    o_data = i_rdata;
            default: o_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: issues bus transactions, stalls the pipeline
// while one is outstanding and bubbles MEM/WB until load data returns.
module lsu_mem_stage
    import riscv_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_valid,
    input  logic [31:0]             i_alu_result,
    input  logic [31:0]             i_store_data,
    input  logic                    i_mem_read,
    input  logic                    i_mem_write,
    input  logic [2:0]              i_funct3,
    input  logic [4:0]              i_rd,
    input  logic                    i_reg_write,
    input  logic                    i_mem_to_reg,
    lsu_mem_stage_if.master         dmem,
    output logic [31:0]             o_read_data,
    output logic [31:0]             o_alu_result,
    output logic [4:0]              o_rd,
    output logic                    o_reg_write,
    output logic                    o_mem_to_reg,
    output logic                    o_stall,
    output logic                    o_mem_fault
);

    lsu_state_e  state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [4:0]  rd_q, rd_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;

    logic        mem_op;
    logic [1:0]  off;
    logic        fault_cond;
    logic        idle_fault;
    logic        req;
    logic        resp_done;
    logic        stall_raw;
    logic [31:0] aligned_data;

    load_align u_load_align (
        .i_rdata  (dmem.rdata),
        .i_off    (off_q),
        .i_funct3 (funct3_q),
        .o_data   (aligned_data)
    );

    // Request, stall and fault decode. Reset forces the externally visible
    // handshake outputs low so an abandoned transaction is not re-issued.
    always_comb begin
        mem_op     = i_valid & (i_mem_read | i_mem_write);
        off        = i_alu_result[1:0];
        fault_cond = lsu_fault(i_funct3, off);
        idle_fault = (state_q == LSU_IDLE) & mem_op & fault_cond;
        req        = ((state_q == LSU_IDLE) & mem_op & ~fault_cond) |
                     (state_q == LSU_WAIT_GNT);
        resp_done  = (state_q == LSU_WAIT_RESP) & dmem.rvalid;
        stall_raw  = ~(((state_q == LSU_IDLE) & ~mem_op) |
                       idle_fault |
                       (req & dmem.gnt & i_mem_write) |
                       resp_done);

        dmem.req    = req & i_reset_n;
        o_stall     = stall_raw & i_reset_n;
        o_mem_fault = idle_fault & i_reset_n;
        dmem.we     = i_mem_write;
        dmem.addr   = {i_alu_result[31:2], 2'b00};
    end

    // Store lane replication and byte enables; loads read the full word.
    always_comb begin
        dmem.be    = 4'b1111;
        dmem.wdata = 32'h0;
        if (i_mem_write) begin
            case (i_funct3)
                F3_B: begin
                    dmem.be    = 4'b0001 << off;
                    dmem.wdata = {4{i_store_data[7:0]}};
                end
                F3_H: begin
                    dmem.be    = 4'b0011 << off;
                    dmem.wdata = {2{i_store_data[15:0]}};
                end
                default: begin
                    dmem.be    = 4'b1111;
                    dmem.wdata = i_store_data;
                end
            endcase
        end
    end

    // MEM/WB outputs: latched load fields during a response, live inputs
    // otherwise, with writeback suppressed while stalled or faulting.
    always_comb begin
        o_alu_result = i_alu_result;
        if (state_q == LSU_WAIT_RESP) begin
            o_rd         = rd_q;
            o_reg_write  = resp_done & reg_write_q;
            o_mem_to_reg = resp_done & mem_to_reg_q;
            o_read_data  = resp_done ? aligned_data : 32'h0;
        end else begin
            o_rd         = i_rd;
            o_reg_write  = i_valid & i_reg_write & ~stall_raw & ~idle_fault;
            o_mem_to_reg = i_valid & i_mem_to_reg & ~stall_raw & ~idle_fault;
            o_read_data  = 32'h0;
        end
    end

    // Next-state logic; load fields are captured on the grant cycle.
    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        funct3_d     = funct3_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        case (state_q)
            LSU_IDLE, LSU_WAIT_GNT: begin
                if (req) begin
                    if (!dmem.gnt) begin
                        state_d = LSU_WAIT_GNT;
                    end else if (i_mem_write) begin
                        state_d = LSU_IDLE;
                    end else begin
                        state_d      = LSU_WAIT_RESP;
                        off_d        = off;
                        funct3_d     = i_funct3;
                        rd_d         = i_rd;
                        reg_write_d  = i_reg_write;
                        mem_to_reg_d = i_mem_to_reg;
                    end
                end
            end
            LSU_WAIT_RESP: begin
                if (dmem.rvalid) begin
                    state_d = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    // State and latched load fields.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= LSU_IDLE;
            off_q        <= 2'b00;
            funct3_q     <= 3'b000;
            rd_q         <= 5'd0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            funct3_q     <= funct3_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

endmodule
